// File: rtl/mrisc_pkg.sv
// Shared types and constants for the KGP MiniRISC fetch path.
package mrisc_pkg;

  localparam int unsigned INSN_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/mrisc_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of {pc, word} pairs with single-cycle flush.
module fetch_queue
  import mrisc_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  fetch_entry_t                 din_i,
  output fetch_entry_t                 dout_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  fetch_entry_t    mem_q [Depth];
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (count_q != CntW'(Depth));

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PtrW'(1);
      if (do_pop)  head_d = head_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (do_push && !flush_i) mem_q[tail_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/mrisc_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem reads, buffers returned words.
module mrisc_fetch_unit
  import mrisc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INSN_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              ins_valid_o,
  input  logic              ins_ready_i,
  output logic [INSN_W-1:0] ins_o,
  output logic [PC_W-1:0]   pc_out_o
);

  localparam int unsigned CntW = $clog2(QDEPTH + 1);
  localparam logic [CntW:0] QDepthW = (CntW + 1)'(QDEPTH);

  fetch_state_e    state_q, state_d;
  logic            req_q, req_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] redirect_pc_al;
  logic [PC_W-1:0] addr_next;

  logic            q_push, q_pop, q_flush, q_empty;
  logic [CntW-1:0] q_count;
  logic [CntW:0]   count_after;
  fetch_entry_t    q_din, q_dout;

  assign redirect_pc_al = redirect_pc_i & ~32'h3;
  assign addr_next      = addr_q + 32'd4;
  assign q_din          = '{pc: addr_q, word: imem_rdata_i};

  assign ins_valid_o = ~q_empty;
  assign q_pop       = ins_valid_o & ins_ready_i & ~redirect_i;
  assign count_after = {1'b0, q_count} + {{CntW{1'b0}}, q_push} - {{CntW{1'b0}}, q_pop};

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    q_push     = 1'b0;
    q_flush    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Nothing is in flight here, so the space test reduces to the queue count.
        if (redirect_i) begin
          q_flush    = 1'b1;
          fetch_pc_d = redirect_pc_al;
          req_d      = 1'b1;
          addr_d     = redirect_pc_al;
          state_d    = StWait;
        end else if ({1'b0, q_count} < QDepthW) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_i) begin
          q_flush    = 1'b1;
          fetch_pc_d = redirect_pc_al;
          if (imem_ack_i) begin
            addr_d = redirect_pc_al;
          end else begin
            state_d = StDrop;
          end
        end else if (imem_ack_i) begin
          q_push     = 1'b1;
          fetch_pc_d = addr_next;
          if (count_after < QDepthW) begin
            addr_d = addr_next;
          end else begin
            req_d   = 1'b0;
            state_d = StIdle;
          end
        end
      end
      StDrop: begin
        // The stale request must complete before the redirected stream starts.
        if (redirect_i) begin
          q_flush    = 1'b1;
          fetch_pc_d = redirect_pc_al;
        end
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_queue #(
    .Depth (QDEPTH)
  ) u_fetch_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (q_flush),
    .din_i   (q_din),
    .dout_o  (q_dout),
    .count_o (q_count),
    .empty_o (q_empty)
  );

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign ins_o       = q_dout.word;
  assign pc_out_o    = q_dout.pc;

endmodule

// File: tb/tb_mrisc_fetch_unit.sv
// Directed bench for mrisc_fetch_unit: reset, streaming, backpressure, redirects, PC wrap.
module tb_mrisc_fetch_unit;

  localparam logic [31:0] K       = 32'hA5A5_0000;
  localparam logic [31:0] WrapPc  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, ack, redir, valid, ready;
  logic [31:0] addr, rdata, redir_pc, ins, pc;
  logic        req_w, ack_w, valid_w, ready_w;
  logic [31:0] addr_w, ins_w, pc_w;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mrisc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_ack_i    (ack),
    .imem_rdata_i  (rdata),
    .redirect_i    (redir),
    .redirect_pc_i (redir_pc),
    .ins_valid_o   (valid),
    .ins_ready_i   (ready),
    .ins_o         (ins),
    .pc_out_o      (pc)
  );

  mrisc_fetch_unit #(
    .RESET_PC (WrapPc),
    .QDEPTH   (2)
  ) dut_wrap (
    .clk_i         (clk),
    .rst_ni        (rst),
    .imem_req_o    (req_w),
    .imem_addr_o   (addr_w),
    .imem_ack_i    (ack_w),
    .imem_rdata_i  (addr_w ^ K),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .ins_valid_o   (valid_w),
    .ins_ready_i   (ready_w),
    .ins_o         (ins_w),
    .pc_out_o      (pc_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst      = 1'b0;
    ack      = 1'b0;
    redir    = 1'b0;
    ready    = 1'b0;
    rdata    = '0;
    redir_pc = '0;
    ack_w    = 1'b0;
    ready_w  = 1'b0;
    repeat (3) step;
    check_eq("rst_req",    32'(req),   32'd0);
    check_eq("rst_addr",   addr,       32'h0);
    check_eq("rst_valid",  32'(valid), 32'd0);
    check_eq("rst_ins",    ins,        32'h0);
    check_eq("rst_pc",     pc,         32'h0);
    check_eq("rst_addr_w", addr_w,     WrapPc);
    rst = 1'b1;
    step;
    check_eq("rel_req",  32'(req), 32'd1);
    check_eq("rel_addr", addr,      32'h0);
  endtask

  initial begin
    rst = 1'b0;

    // Streaming at one instruction per cycle.
    apply_reset;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_eq("stream_addr", addr,      32'(4 * i));
      check_eq("stream_req",  32'(req),  32'd1);
      if (i > 0) begin
        check_eq("stream_valid", 32'(valid), 32'd1);
        check_eq("stream_pc",    pc,         32'(4 * (i - 1)));
        check_eq("stream_ins",   ins,        32'(4 * (i - 1)) ^ K);
      end
      ack   = 1'b1;
      rdata = addr ^ K;
      step;
    end
    ack = 1'b0;
    check_eq("stream_last_pc", pc, 32'd20);

    // Backpressure: two entries fill the queue, then the request drops.
    apply_reset;
    ack   = 1'b1;
    rdata = 32'h0 ^ K;
    step;
    check_eq("bp_addr4",  addr,       32'h4);
    check_eq("bp_valid",  32'(valid), 32'd1);
    check_eq("bp_pc0",    pc,         32'h0);
    rdata = 32'h4 ^ K;
    step;
    ack = 1'b0;
    check_eq("bp_req_drop", 32'(req), 32'd0);
    check_eq("bp_pc0_held", pc,       32'h0);
    step;
    check_eq("bp_req_idle", 32'(req), 32'd0);
    ready = 1'b1;
    step;
    check_eq("bp_pc4",     pc,       32'h4);
    check_eq("bp_ins4",    ins,      32'h4 ^ K);
    check_eq("bp_req_off", 32'(req), 32'd0);
    step;
    check_eq("bp_req8",   32'(req),   32'd1);
    check_eq("bp_addr8",  addr,       32'h8);
    check_eq("bp_empty",  32'(valid), 32'd0);
    ack   = 1'b1;
    rdata = 32'h8 ^ K;
    step;
    ack = 1'b0;
    check_eq("bp_pc8", pc, 32'h8);

    // Redirect while waiting on 0x10 with a delayed ack.
    apply_reset;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ack   = 1'b1;
      rdata = addr ^ K;
      step;
    end
    ack = 1'b0;
    check_eq("rd_addr10", addr, 32'h10);
    check_eq("rd_pcC",    pc,   32'hC);
    step;
    check_eq("rd_hold1", addr, 32'h10);
    step;
    check_eq("rd_hold2", addr, 32'h10);
    redir    = 1'b1;
    redir_pc = 32'h40;
    step;
    redir = 1'b0;
    check_eq("rd_drop_addr",  addr,       32'h10);
    check_eq("rd_drop_req",   32'(req),   32'd1);
    check_eq("rd_drop_valid", 32'(valid), 32'd0);
    ack   = 1'b1;
    rdata = 32'h10 ^ K;
    step;
    ack = 1'b0;
    check_eq("rd_idle_req",   32'(req),   32'd0);
    check_eq("rd_idle_valid", 32'(valid), 32'd0);
    step;
    check_eq("rd_req40",   32'(req),   32'd1);
    check_eq("rd_addr40",  addr,       32'h40);
    check_eq("rd_valid40", 32'(valid), 32'd0);
    ack   = 1'b1;
    rdata = 32'h40 ^ K;
    step;
    ack = 1'b0;
    check_eq("rd_out_valid", 32'(valid), 32'd1);
    check_eq("rd_out_pc",    pc,         32'h40);
    check_eq("rd_out_ins",   ins,        32'h40 ^ K);

    // Redirect, ack and pop all in one cycle.
    apply_reset;
    ack   = 1'b1;
    rdata = 32'h0 ^ K;
    step;
    check_eq("sim_valid_pre", 32'(valid), 32'd1);
    ready    = 1'b1;
    rdata    = 32'h4 ^ K;
    redir    = 1'b1;
    redir_pc = 32'h103;
    step;
    redir = 1'b0;
    ack   = 1'b0;
    check_eq("sim_flushed", 32'(valid), 32'd0);
    check_eq("sim_req",     32'(req),   32'd1);
    check_eq("sim_addr",    addr,       32'h100);
    ack   = 1'b1;
    rdata = 32'h100 ^ K;
    step;
    ack = 1'b0;
    check_eq("sim_pc",     pc,   32'h100);
    check_eq("sim_ins",    ins,  32'h100 ^ K);
    check_eq("sim_addr_n", addr, 32'h104);

    // PC wrap on the second instance.
    apply_reset;
    ack_w   = 1'b1;
    ready_w = 1'b1;
    check_eq("wrap_a0", addr_w, 32'hFFFF_FFF8);
    step;
    check_eq("wrap_a1", addr_w, 32'hFFFF_FFFC);
    check_eq("wrap_p0", pc_w,   32'hFFFF_FFF8);
    step;
    check_eq("wrap_a2", addr_w, 32'h0000_0000);
    check_eq("wrap_p1", pc_w,   32'hFFFF_FFFC);
    step;
    check_eq("wrap_a3", addr_w, 32'h0000_0004);
    check_eq("wrap_p2", pc_w,   32'h0000_0000);
    check_eq("wrap_i2", ins_w,  32'h0000_0000 ^ K);
    check_eq("wrap_v",  32'(valid_w), 32'd1);
    check_eq("wrap_r",  32'(req_w),   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mrisc_fetch_unit.md
# mrisc_fetch_unit

Instruction fetch stage for the KGP MiniRISC core. It owns the program counter and issues word reads to instruction memory over a request/acknowledge handshake. Returned words are buffered in a small queue and handed to the decode/control stage as {ins, pc} pairs using a valid/ready handshake. It also accepts PC redirects from branch resolution, which flush buffered and in-flight fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QDEPTH, 2, instruction queue entries; power of two, 2 or more

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  byte address of fetch; stable while imem_req is high
- imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- redirect  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] are ignored and forced to 0
- ins_valid  out  1  queue head valid
- ins_ready  in  1  consumer accepts the head this cycle
- ins  out  32  head instruction word
- pc_out  out  32  address of head instruction

## Operation
- Registers:
  - fetch_pc: next address to request.
  - State machine with states IDLE, WAIT, DROP.
  - Queue: QDEPTH entries of {pc, word}, with head pointer, tail pointer and count.
- A request may start only when count + in-flight < QDEPTH. At most one request is ever outstanding.
- IDLE:
  - If a request may start, raise imem_req with imem_addr = fetch_pc and go to WAIT.
- WAIT:
  - On imem_ack, push {imem_addr, imem_rdata} into the queue and set fetch_pc += 4 (mod 2^32, wraps from FFFF_FFFC to 0).
  - If space remains after this cycle's push and pop, keep imem_req high with the new address and stay in WAIT. This gives back-to-back fetches at one per cycle. Otherwise drop imem_req and go to IDLE.
- Redirect (highest priority; overrides push and pop in the same cycle):
  - Queue is flushed, count goes to 0, and fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - In WAIT with no ack this cycle: go to DROP. imem_req and imem_addr stay unchanged, because the handshake forbids withdrawing a request.
  - In WAIT with ack this cycle: the returned data is discarded. Request redirect_pc next cycle and stay in WAIT.
  - In IDLE: request redirect_pc next cycle.
  - In DROP: update fetch_pc only and remain in DROP.
- DROP:
  - On imem_ack, discard the data and go to IDLE. The request at fetch_pc is issued the following cycle.
- Pop: when ins_valid && ins_ready && !redirect, advance head and decrement count.
- Push and pop in the same cycle leave count unchanged.
- Overflow cannot occur because of the issue gating. An ack received in IDLE is a protocol error and is ignored.

## Timing
- Values while rst is low:
  - imem_req = 0, imem_addr = RESET_PC, ins_valid = 0, ins = 0, pc_out = 0.
  - State is IDLE, queue is empty, fetch_pc = RESET_PC.
- First rising clk edge after rst goes high: imem_req = 1, imem_addr = RESET_PC.
- imem_ack is legal in any cycle that imem_req is high, including the first.
- Latency from ack to ins_valid: 1 cycle, because the queue is registered. Data never bypasses the queue.
- ins_valid drops the cycle after a redirect, and stays low until the first ack of the new stream.
- Peak throughput is 1 instruction per cycle when imem_ack is high every cycle and ins_ready = 1.
- If rst goes low mid-operation, every register clears immediately. Any in-flight response is not tracked after reset.

## Structure
- Shared package mrisc_pkg holds:
  - INSN_W = 32 and PC_W = 32.
  - Fetch FSM state enum {IDLE, WAIT, DROP}.
  - RESET_PC default value.
- Sub-module fetch_queue: synchronous FIFO with flush.
  - Ports: push, pop, flush, din {pc, word}, dout, count, empty.
  - The FSM and PC logic stay in mrisc_fetch_unit.

## Test plan
- Reset: hold rst low for 3 cycles, then release.
  - Expect imem_req = 0, imem_addr = 0, ins_valid = 0 while rst is low.
  - Expect imem_req = 1 with imem_addr = 0 at the first edge after release.
- Streaming: imem_ack every cycle with rdata = addr ^ 32'hA5A5_0000, and ins_ready = 1.
  - Expect addresses 0, 4, 8, ... and ins_valid from the cycle after the first ack.
  - Expect pc_out and ins to match one pair per cycle.
- Backpressure: ins_ready = 0, memory acks each request.
  - Expect two entries (pc 0 and 4) queued, then imem_req low.
  - Raise ins_ready and expect the next request to be 8 with no lost or duplicated pc.
- Redirect in flight: ack delayed 3 cycles, then redirect to 0x40 while WAITing on addr 0x10.
  - Expect imem_addr to stay 0x10 until its ack, and that data to be discarded.
  - Expect the next request at 0x40 and ins_valid low until 0x40 returns.
- Simultaneous events: redirect to 0x103, ack, and a pop all in the same cycle.
  - Expect the queue empty next cycle, the acked data dropped, and the next imem_addr to be 0x100.
- PC wrap: RESET_PC = FFFF_FFF8 with continuous acks.
  - Expect addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
